// File: rtl/dmem_sp.sv
// Single-port data memory with request/ready handshake, one-cycle registered
// read, out-of-range flagging and an optional zero-fill sequence after reset.
module dmem_sp #(
    parameter int DW             = 8,
    parameter int AW             = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] Iea,
    input  logic [DW-1:0] IRa,
    input  logic          DMCR,
    input  logic          Ireq,
    output logic          Ordy,
    output logic [DW-1:0] ODM,
    output logic          Ovalid,
    output logic          Oerr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic            accept;
    logic            in_range;
    logic [PW-1:0]   idx;
    logic            we;
    logic [PW-1:0]   waddr;
    logic [DW-1:0]   wdata;

    assign Ordy     = (state == RUN);
    assign accept   = Ireq && Ordy;
    assign in_range = ({1'b0, Iea} < LIMIT);
    assign idx      = Iea[PW-1:0];

    // The clear sequencer and accepted writes share the single write port
    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        wdata = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                we = 1'b1;
            end else if (accept && DMCR && in_range) begin
                we    = 1'b1;
                waddr = idx;
                wdata = IRa;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            ptr    <= '0;
            ODM    <= '0;
            Ovalid <= 1'b0;
            Oerr   <= 1'b0;
        end else begin
            Ovalid <= 1'b0;
            Oerr   <= 1'b0;
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= RUN;
                        ptr   <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        Oerr <= !in_range;
                        if (!DMCR) begin
                            Ovalid <= 1'b1;
                            ODM    <= in_range ? mem[idx] : '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sp.sv
// Randomised self-checking bench for dmem_sp across three parameter sets.
module tb_dmem_sp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: 8x256, clear on reset
    logic       a_rst, a_cr, a_req, a_rdy, a_vl, a_er;
    logic [7:0] a_ea, a_ra, a_dm;
    // B: 8x200 in an 8-bit space, contents retained
    logic       b_rst, b_cr, b_req, b_rdy, b_vl, b_er;
    logic [7:0] b_ea, b_ra, b_dm;
    // C: 16x16, 4-bit addresses, clear on reset
    logic        c_rst, c_cr, c_req, c_rdy, c_vl, c_er;
    logic [3:0]  c_ea;
    logic [15:0] c_ra, c_dm;

    dmem_sp #(.DW(8), .AW(8), .DEPTH(256), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(a_rst), .Iea(a_ea), .IRa(a_ra), .DMCR(a_cr),
        .Ireq(a_req), .Ordy(a_rdy), .ODM(a_dm), .Ovalid(a_vl), .Oerr(a_er)
    );
    dmem_sp #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .rst(b_rst), .Iea(b_ea), .IRa(b_ra), .DMCR(b_cr),
        .Ireq(b_req), .Ordy(b_rdy), .ODM(b_dm), .Ovalid(b_vl), .Oerr(b_er)
    );
    dmem_sp #(.DW(16), .AW(4), .DEPTH(16), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .rst(c_rst), .Iea(c_ea), .IRa(c_ra), .DMCR(c_cr),
        .Ireq(c_req), .Ordy(c_rdy), .ODM(c_dm), .Ovalid(c_vl), .Oerr(c_er)
    );

    // Reference contents and the expected held read data
    logic [7:0]  ma [256];
    logic [7:0]  mb [200];
    logic [15:0] mc [16];
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [15:0] c_exp;

    task automatic a_drive(input logic r, input logic w,
                           input logic [7:0] ad, input logic [7:0] d);
        a_req = r; a_cr = w; a_ea = ad; a_ra = d;
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    task automatic b_drive(input logic r, input logic w,
                           input logic [7:0] ad, input logic [7:0] d);
        b_req = r; b_cr = w; b_ea = ad; b_ra = d;
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic c_drive(input logic r, input logic w,
                           input logic [3:0] ad, input logic [15:0] d);
        c_req = r; c_cr = w; c_ea = ad; c_ra = d;
        @(posedge clk); #1;
        c_req = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_req = 0; b_req = 0; c_req = 0;
        a_cr = 0; b_cr = 0; c_cr = 0;
        a_ea = 0; b_ea = 0; c_ea = 0;
        a_ra = 0; b_ra = 0; c_ra = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_rdy !== 1'b0 || a_dm !== 8'h00 || a_vl !== 1'b0 || a_er !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: rdy=%b odm=%h valid=%b err=%b, want 0 00 0 0",
                     a_rdy, a_dm, a_vl, a_er);
        end
        checks++;
        if (b_rdy !== 1'b1 || b_dm !== 8'h00 || b_vl !== 1'b0 || b_er !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: rdy=%b odm=%h valid=%b err=%b, want 1 00 0 0",
                     b_rdy, b_dm, b_vl, b_er);
        end
        checks++;
        if (c_rdy !== 1'b0 || c_dm !== 16'h0 || c_vl !== 1'b0) begin
            errors++;
            $display("FAIL reset_c: rdy=%b odm=%h valid=%b, want 0 0000 0",
                     c_rdy, c_dm, c_vl);
        end
        b_rst = 0;
        a_exp = 0; b_exp = 0; c_exp = 0;
    endtask

    task automatic test_clear_a();
        int cnt = 0;
        a_rst = 0;
        while (a_rdy !== 1'b1 && cnt < 1000) begin
            // a write attempt in the middle of the clear must be ignored
            a_req = (cnt == 100); a_cr = 1; a_ea = 8'd5; a_ra = 8'h77;
            @(posedge clk); #1;
            cnt++;
            a_req = 0;
        end
        checks++;
        if (cnt != 256) begin
            errors++;
            $display("FAIL clear_len_a: ready after %0d cycles, want 256", cnt);
        end
        for (int i = 0; i < 256; i++) ma[i] = 8'h00;
        a_drive(1, 0, 8'd81, 8'h00);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'h00 || a_er !== 1'b0) begin
            errors++;
            $display("FAIL clear_read81: valid=%b odm=%h err=%b, want 1 00 0",
                     a_vl, a_dm, a_er);
        end
        a_drive(0, 0, 8'd0, 8'h00);
        checks++;
        if (a_vl !== 1'b0 || a_dm !== 8'h00) begin
            errors++;
            $display("FAIL valid_pulse: valid=%b odm=%h, want 0 00", a_vl, a_dm);
        end
        a_drive(1, 0, 8'd5, 8'h00);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'h00) begin
            errors++;
            $display("FAIL clear_ignore_req: valid=%b odm=%h, want 1 00", a_vl, a_dm);
        end
        a_exp = 8'h00;
    endtask

    task automatic test_back_to_back();
        a_drive(1, 1, 8'd81, 8'd2);  ma[81] = 8'd2;
        checks++;
        if (a_vl !== 1'b0 || a_er !== 1'b0 || a_dm !== a_exp) begin
            errors++;
            $display("FAIL write_no_valid: valid=%b err=%b odm=%h, want 0 0 %h",
                     a_vl, a_er, a_dm, a_exp);
        end
        a_drive(1, 1, 8'd31, 8'd5);  ma[31] = 8'd5;
        a_drive(1, 0, 8'd81, 8'd0);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'd2) begin
            errors++;
            $display("FAIL b2b_first: valid=%b odm=%h, want 1 02", a_vl, a_dm);
        end
        a_drive(1, 0, 8'd31, 8'd0);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'd5) begin
            errors++;
            $display("FAIL b2b_second: valid=%b odm=%h, want 1 05", a_vl, a_dm);
        end
        a_drive(0, 0, 8'd0, 8'd0);
        checks++;
        if (a_vl !== 1'b0 || a_dm !== 8'd5) begin
            errors++;
            $display("FAIL odm_hold: valid=%b odm=%h, want 0 05", a_vl, a_dm);
        end
        a_exp = 8'd5;
    endtask

    task automatic test_write_then_read();
        a_drive(1, 1, 8'd7, 8'hA5);  ma[7] = 8'hA5;
        a_drive(1, 0, 8'd7, 8'h00);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'hA5) begin
            errors++;
            $display("FAIL write_then_read: valid=%b odm=%h, want 1 a5", a_vl, a_dm);
        end
        a_exp = 8'hA5;
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 400; i++) begin
            logic r, w, ev;
            logic [7:0] ad, d;
            r  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            ad = 8'($urandom);
            d  = 8'($urandom);
            a_drive(r, w, ad, d);
            ev = r && !w;
            if (r && w) ma[ad] = d;
            if (ev) a_exp = ma[ad];
            checks++;
            if (a_vl !== ev || a_dm !== a_exp || a_er !== 1'b0) begin
                errors++;
                $display("FAIL rand_a[%0d] addr=%0d: valid=%b odm=%h err=%b, want %b %h 0",
                         i, ad, a_vl, a_dm, a_er, ev, a_exp);
            end
        end
    endtask

    task automatic test_reclear_a();
        int cnt = 0;
        a_drive(1, 1, 8'd81, 8'h3C);
        a_rst = 1; #1;
        checks++;
        if (a_rdy !== 1'b0 || a_dm !== 8'h00 || a_vl !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b odm=%h valid=%b, want 0 00 0",
                     a_rdy, a_dm, a_vl);
        end
        @(posedge clk); #1;
        a_rst = 0;
        repeat (100) @(posedge clk);
        #1;
        a_rst = 1;
        @(posedge clk); #1;
        a_rst = 0;
        while (a_rdy !== 1'b1 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt != 256) begin
            errors++;
            $display("FAIL reclear_len: ready after %0d cycles, want 256", cnt);
        end
        a_drive(1, 0, 8'd81, 8'h00);
        checks++;
        if (a_vl !== 1'b1 || a_dm !== 8'h00) begin
            errors++;
            $display("FAIL reclear_zero: valid=%b odm=%h, want 1 00", a_vl, a_dm);
        end
    endtask

    task automatic test_range_b();
        b_drive(1, 1, 8'd10, 8'h11);
        checks++;
        if (b_er !== 1'b0 || b_vl !== 1'b0) begin
            errors++;
            $display("FAIL b_inrange_write: err=%b valid=%b, want 0 0", b_er, b_vl);
        end
        b_drive(1, 1, 8'd82, 8'h22);
        b_drive(1, 1, 8'd210, 8'd9);
        checks++;
        if (b_er !== 1'b1 || b_vl !== 1'b0) begin
            errors++;
            $display("FAIL b_oor_write: err=%b valid=%b, want 1 0", b_er, b_vl);
        end
        b_drive(1, 0, 8'd210, 8'd0);
        checks++;
        if (b_er !== 1'b1 || b_vl !== 1'b1 || b_dm !== 8'h00) begin
            errors++;
            $display("FAIL b_oor_read: err=%b valid=%b odm=%h, want 1 1 00",
                     b_er, b_vl, b_dm);
        end
        b_drive(1, 0, 8'd10, 8'd0);
        checks++;
        if (b_er !== 1'b0 || b_vl !== 1'b1 || b_dm !== 8'h11) begin
            errors++;
            $display("FAIL b_word10: err=%b valid=%b odm=%h, want 0 1 11",
                     b_er, b_vl, b_dm);
        end
        b_drive(1, 0, 8'd82, 8'd0);
        checks++;
        if (b_vl !== 1'b1 || b_dm !== 8'h22) begin
            errors++;
            $display("FAIL b_word82: valid=%b odm=%h, want 1 22", b_vl, b_dm);
        end
        b_drive(0, 0, 8'd0, 8'd0);
        checks++;
        if (b_er !== 1'b0 || b_vl !== 1'b0 || b_dm !== 8'h22) begin
            errors++;
            $display("FAIL b_idle: err=%b valid=%b odm=%h, want 0 0 22",
                     b_er, b_vl, b_dm);
        end
    endtask

    task automatic test_retain_b();
        b_drive(1, 1, 8'd31, 8'd5);
        b_rst = 1; #1;
        checks++;
        if (b_rdy !== 1'b1 || b_dm !== 8'h00 || b_vl !== 1'b0) begin
            errors++;
            $display("FAIL b_reset_out: rdy=%b odm=%h valid=%b, want 1 00 0",
                     b_rdy, b_dm, b_vl);
        end
        @(posedge clk); #1;
        b_rst = 0;
        b_drive(1, 0, 8'd31, 8'd0);
        checks++;
        if (b_vl !== 1'b1 || b_dm !== 8'd5) begin
            errors++;
            $display("FAIL b_retain: valid=%b odm=%h, want 1 05", b_vl, b_dm);
        end
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            b_drive(1, 1, 8'(i), d);
            mb[i] = d;
        end
        b_exp = 8'd5;
        for (int i = 0; i < 300; i++) begin
            logic r, w, inr, ev, ee;
            logic [7:0] ad, d;
            r   = ($urandom_range(0, 3) != 0);
            w   = 1'($urandom_range(0, 1));
            ad  = 8'($urandom);
            d   = 8'($urandom);
            inr = (ad < 200);
            b_drive(r, w, ad, d);
            ev = r && !w;
            ee = r && !inr;
            if (r && w && inr) mb[ad] = d;
            if (ev) b_exp = inr ? mb[ad] : 8'h00;
            checks++;
            if (b_vl !== ev || b_er !== ee || b_dm !== b_exp) begin
                errors++;
                $display("FAIL rand_b[%0d] addr=%0d: valid=%b err=%b odm=%h, want %b %b %h",
                         i, ad, b_vl, b_er, b_dm, ev, ee, b_exp);
            end
        end
    endtask

    task automatic test_wide_c();
        int cnt = 0;
        c_rst = 0;
        while (c_rdy !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL clear_len_c: ready after %0d cycles, want 16", cnt);
        end
        for (int i = 0; i < 16; i++) mc[i] = 16'h0;
        c_drive(1, 1, 4'd15, 16'hBEEF);  mc[15] = 16'hBEEF;
        c_drive(1, 0, 4'd15, 16'h0);
        checks++;
        if (c_vl !== 1'b1 || c_dm !== 16'hBEEF || c_er !== 1'b0) begin
            errors++;
            $display("FAIL c_read15: valid=%b odm=%h err=%b, want 1 beef 0",
                     c_vl, c_dm, c_er);
        end
        c_drive(1, 0, 4'd0, 16'h0);
        checks++;
        if (c_vl !== 1'b1 || c_dm !== 16'h0000) begin
            errors++;
            $display("FAIL c_read0: valid=%b odm=%h, want 1 0000", c_vl, c_dm);
        end
        c_exp = 16'h0;
        for (int i = 0; i < 200; i++) begin
            logic r, w, ev;
            logic [3:0] ad;
            logic [15:0] d;
            r  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            ad = 4'($urandom);
            d  = 16'($urandom);
            c_drive(r, w, ad, d);
            ev = r && !w;
            if (r && w) mc[ad] = d;
            if (ev) c_exp = mc[ad];
            checks++;
            if (c_vl !== ev || c_er !== 1'b0 || c_dm !== c_exp) begin
                errors++;
                $display("FAIL rand_c[%0d] addr=%0d: valid=%b err=%b odm=%h, want %b 0 %h",
                         i, ad, c_vl, c_er, c_dm, ev, c_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_a();
        test_back_to_back();
        test_write_then_read();
        test_random_a();
        test_reclear_a();
        test_range_b();
        test_retain_b();
        test_random_b();
        test_wide_c();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_sp.md
# dmem_sp

Parametrised single-port data memory with a request/ready handshake, registered read path and a hardware clear-on-reset sequencer. It is the next-generation data memory of the 8-bit RISC processor: width and depth are generic, reads have a defined one-cycle latency with a valid strobe, and out-of-range accesses are flagged. It sits between the execute stage's effective-address/register-operand outputs and the write-back mux.

## Interface
- DW, 8, data word width in bits
- AW, 8, address width in bits
- DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**AW
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents retained across reset

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- Iea  in  AW  word address
- IRa  in  DW  write data
- DMCR  in  1  access type: 1 = write, 0 = read
- Ireq  in  1  access request
- Ordy  out  1  block accepts a request this cycle
- ODM  out  DW  registered read data
- Ovalid  out  1  ODM updated this cycle (one-cycle pulse)
- Oerr  out  1  one-cycle pulse: accepted access had Iea >= DEPTH

## Operation
- States: CLEAR, RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- Reset values: ODM=0, Ovalid=0, Oerr=0, clear pointer=0; Ordy=0 in CLEAR, 1 in RUN.
- CLEAR: writes 0 to word[ptr] each cycle, ptr increments; after writing word DEPTH-1, go to RUN. Ordy=0; Ireq ignored (no error, no queueing).
- RUN: Ordy=1 every cycle. Access accepted on an edge where Ireq=1 and Ordy=1.
- Accepted write (DMCR=1, Iea<DEPTH): word[Iea] <= IRa. ODM, Ovalid unchanged/low.
- Accepted read (DMCR=0, Iea<DEPTH): ODM <= word[Iea], Ovalid <= 1.
- Out-of-range (Iea>=DEPTH): write dropped; read returns ODM <= 0 with Ovalid=1; Oerr=1 in both cases.
- ODM holds last read value until next accepted read; Ovalid/Oerr low otherwise.
- Single port: exactly one access per cycle; DMCR selects type, no conflict case.
- Reset asserted mid-CLEAR: pointer returns to 0, clear restarts from word 0.
- Reset asserted in RUN with CLEAR_ON_RESET=0: outputs reset, memory contents retained.
- Inputs sampled only when accepted; Iea/IRa/DMCR don't-care when Ireq=0.

## Timing
- Read latency 1: request accepted at edge N -> ODM valid, Ovalid=1 in cycle after edge N, cleared at edge N+1 unless another read accepted.
- Back-to-back reads every cycle: Ovalid stays high, ODM updates each cycle.
- Write effective at accepting edge; read accepted on the next edge returns new data (write-then-read, no hazard).
- Clear duration: exactly DEPTH cycles after rst deasserts; Ordy rises after the DEPTH-th edge.
- Oerr aligned with Ovalid for reads; for writes pulses the cycle after the accepting edge.
- No combinational path from inputs to outputs except none; all outputs registered (Ordy derived from state register).

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=256: Ordy=0 for 256 cycles then 1; read Iea=81 -> ODM=0, Ovalid=1 one cycle.
- Write Iea=81 IRa=2, write Iea=31 IRa=5, read 81 then 31 back-to-back -> ODM=2 then 5 on consecutive cycles, Ovalid high 2 cycles.
- Write Iea=7 IRa=0xA5 then read Iea=7 next cycle -> ODM=0xA5; Ireq pulsed during CLEAR -> no write occurs, later read returns 0.
- DEPTH=200: write Iea=210 IRa=9 -> Oerr pulse, no word modified; read Iea=210 -> ODM=0, Ovalid=1, Oerr=1.
- rst asserted at cycle 100 of CLEAR -> Ordy stays 0 for full DEPTH cycles after release; CLEAR_ON_RESET=0: write 31<=5, pulse rst, read 31 -> 5.
- DW=16, AW=4, DEPTH=16: write 15<=0xBEEF, read 15 -> 0xBEEF; read address 0 -> 0 after clear.
